// File: rtl/llr_mem_pkg.sv
// Shared definitions for the channel-LLR store controller: state encoding,
// output FIFO depth, default widths and the pass-count clamp.
package llr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } llr_state_e;

  localparam int FIFO_DEPTH         = 2;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_A_WIDTH        = 8;
  localparam int DEF_BLOCK_LEN      = 256;
  localparam int PASS_WIDTH         = 4;

  // A request for zero passes still reads the codeword once.
  function automatic logic [PASS_WIDTH-1:0] clamp_passes(input logic [PASS_WIDTH-1:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/llr_out_fifo.sv
// Two-entry synchronous FIFO holding {last, data} words between the RAM read
// port and the decoder stream. The head entry is presented directly so the
// output only changes on a pop or on a push into an empty FIFO.
module llr_out_fifo
  import llr_mem_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;

  // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);
  assign count = count_r;

endmodule

// File: rtl/llr_mem_ctrl.sv
// Channel-LLR store controller: writes one codeword into a single-port
// synchronous-read RAM, then streams it back one or more times to the
// decoder over valid/ready, with out_last on the final word of each pass.
module llr_mem_ctrl
  import llr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int BLOCK_LEN  = DEF_BLOCK_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            num_passes,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [A_WIDTH-1:0]    ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [A_WIDTH:0] LAST_IDX = (A_WIDTH+1)'(BLOCK_LEN - 1);
  localparam logic [A_WIDTH:0] CNT_ONE  = (A_WIDTH+1)'(1);

  llr_state_e        state_r, state_s;
  logic [A_WIDTH:0]  wr_cnt_r, rd_cnt_r;
  logic [3:0]        pass_cnt_r, passes_r;
  logic              inflight_r, inflight_last_r;
  logic              in_ready_r, busy_r, done_r;

  logic              wr_fire_s, rd_issue_s, issue_ok_s, pop_s, done_s;
  logic [2:0]        occ_s, credit_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [1:0]        fifo_count_s;
  logic [DATA_WIDTH:0] fifo_head_s;

  assign wr_fire_s = (state_r == ST_LOAD) && in_valid && in_ready_r;
  assign pop_s     = !fifo_empty_s && out_ready;

  // A word leaving the FIFO this cycle frees a slot, so it is credited back;
  // this keeps a 1 word/cycle stream without ever overfilling the FIFO.
  assign occ_s      = {1'b0, fifo_count_s} + {2'b00, inflight_r};
  assign credit_s   = occ_s - {2'b00, pop_s};
  assign issue_ok_s = (credit_s < 3'd2) && !(fifo_full_s && !pop_s);
  assign rd_issue_s = (state_r == ST_READ) && (pass_cnt_r != passes_r) && issue_ok_s;

  // The final word of the final pass is the only last-tagged word left once
  // every read has been issued and nothing is in flight behind it.
  assign done_s = pop_s && fifo_head_s[DATA_WIDTH] && (pass_cnt_r == passes_r) &&
                  !inflight_r && (fifo_count_s == 2'd1);

  // Next-state selection; READ lingers for the done cycle so a coincident start is dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_LOAD;
        else       state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (wr_fire_s && (wr_cnt_r == LAST_IDX)) state_s = ST_READ;
        else                                     state_s = ST_LOAD;
      end
      ST_READ: begin
        if (done_r) state_s = ST_IDLE;
        else        state_s = ST_READ;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // RAM port: a write on each accepted input word, otherwise a paced read.
  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (wr_fire_s) begin
      ram_cs   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = wr_cnt_r[A_WIDTH-1:0];
      ram_din  = in_data;
    end else if (rd_issue_s) begin
      ram_cs   = 1'b1;
      ram_addr = rd_cnt_r[A_WIDTH-1:0];
    end else begin
      ram_cs   = 1'b0;
    end
  end

  // State, counters, read-pipeline tag and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      wr_cnt_r        <= '0;
      rd_cnt_r        <= '0;
      pass_cnt_r      <= 4'd0;
      passes_r        <= 4'd0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      in_ready_r      <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      state_r         <= state_s;
      in_ready_r      <= (state_s == ST_LOAD);
      busy_r          <= (state_s != ST_IDLE);
      done_r          <= done_s;
      inflight_r      <= rd_issue_s;
      inflight_last_r <= rd_issue_s && (rd_cnt_r == LAST_IDX);
      if ((state_r == ST_IDLE) && start) begin
        passes_r   <= clamp_passes(num_passes);
        wr_cnt_r   <= '0;
        rd_cnt_r   <= '0;
        pass_cnt_r <= 4'd0;
      end else begin
        if (wr_fire_s) begin
          wr_cnt_r <= wr_cnt_r + CNT_ONE;
        end
        if (rd_issue_s) begin
          if (rd_cnt_r == LAST_IDX) begin
            rd_cnt_r   <= '0;
            pass_cnt_r <= pass_cnt_r + 4'd1;
          end else begin
            rd_cnt_r <= rd_cnt_r + CNT_ONE;
          end
        end
      end
    end
  end

  llr_out_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_r),
    .push_data ({inflight_last_r, ram_dout}),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign out_valid = !fifo_empty_s;
  assign out_data  = fifo_head_s[DATA_WIDTH-1:0];
  assign out_last  = fifo_head_s[DATA_WIDTH];

endmodule

// File: doc/llr_mem_ctrl.md
Name: llr_mem_ctrl

Overview:
Front-end controller for the LDPC decoder's channel-LLR store. It accepts a stream of quantised LLRs and writes one codeword into the single-port, synchronous-read RAM (RAM_SP_SR_RW). It then reads that codeword back sequentially, one or more times, and presents it to the downstream decoder core over a valid/ready stream. This block is the only master of the RAM's clk/address/data_in/we/cs/data_out port.

Parameters:
DATA_WIDTH, 8, LLR word width; must match the RAM.
A_WIDTH, 8, RAM address width; must match the RAM.
BLOCK_LEN, 256, codeword length in words; 2 <= BLOCK_LEN <= 2^A_WIDTH.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begins load of a new codeword; honoured only in IDLE.
num_passes  in  4  number of read passes; sampled on accepted start; 0 is treated as 1.
in_data  in  DATA_WIDTH  incoming LLR.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts in_data this cycle.
out_data  out  DATA_WIDTH  LLR to the decoder.
out_valid  out  1  out_data is valid.
out_ready  in  1  decoder accepts out_data.
out_last  out  1  marks the final word (index BLOCK_LEN-1) of each pass; valid with out_valid.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when the last word of the last pass is accepted.
ram_cs  out  1  RAM chip select.
ram_we  out  1  RAM write enable.
ram_addr  out  A_WIDTH  RAM address.
ram_din  out  DATA_WIDTH  RAM write data.
ram_dout  in  DATA_WIDTH  RAM read data; valid one cycle after the read is issued.

Behaviour:
- Reset values: state=IDLE; in_ready, out_valid, out_last, busy, done, ram_cs and ram_we are all 0; ram_addr, ram_din and out_data are 0; all counters are 0. RAM contents are not cleared.
- Reset mid-operation aborts the operation immediately. No done pulse; buffered output words are discarded.
- States and transitions:
  - IDLE: on start, latch passes = max(num_passes, 1), clear counters, go to LOAD. start in any other state is ignored.
  - LOAD: in_ready=1. On in_valid&&in_ready, drive ram_cs=1, ram_we=1, ram_addr=wr_cnt, ram_din=in_data in the same cycle, then wr_cnt++.
    - On the transfer where wr_cnt==BLOCK_LEN-1, go to READ; in_ready drops the next cycle.
  - READ: in_ready=0. A read is issued (ram_cs=1, ram_we=0, ram_addr=rd_cnt) only when output-buffer occupancy plus in-flight reads is < 2.
    - rd_cnt wraps BLOCK_LEN-1 -> 0 and increments pass_cnt. No reads are issued once pass_cnt==passes.
    - When all passes have been issued and the last word has been accepted downstream, pulse done and go to IDLE.
  - When no access is made, ram_cs=0 and ram_we=0.
- Read latency: ram_dout is captured into a 2-entry output FIFO one cycle after the read is issued. First out_valid occurs 2 cycles after entering READ. With out_ready held at 1, throughput is 1 word/cycle.
- Handshake rules:
  - out_data, out_valid and out_last hold stable while out_valid && !out_ready.
  - A transfer happens on out_valid && out_ready.
  - in_valid is ignored outside LOAD.
- out_last is carried in the FIFO with its data word; it is set when the word's address is BLOCK_LEN-1.
- Simultaneous events:
  - A FIFO push and pop in the same cycle leave occupancy unchanged.
  - A done pulse and a start in the same cycle: start is ignored, because the state is still READ.
- Counter widths: wr_cnt and rd_cnt are A_WIDTH+1 bits; pass_cnt is 4 bits.

Decomposition:
- Shared package llr_mem_pkg holds:
  - the state encoding enum (IDLE, LOAD, READ);
  - localparam FIFO_DEPTH=2;
  - the default widths.
- One natural sub-module: llr_out_fifo, a 2-entry synchronous FIFO carrying {last, data}, with push/pop/full/empty/count.

Test Plan:
- Load 256 random 8-bit words with in_valid held at 1 and num_passes=1 -> RAM[i] equals word i. Readback produces 256 words in order; out_last is set on word 255; done fires exactly once; busy then returns to 0.
- num_passes=3 with out_ready=1 -> 768 output words, with out_last at word indices 255, 511 and 767. done comes on the cycle after the 768th transfer and is 1 cycle wide.
- out_ready toggling in a pseudo-random pattern (deassert 50%) -> no words are lost or duplicated. out_data stays stable while stalled, and the RAM is never read with FIFO count+inflight > 2.
- in_valid with gaps, e.g. valid only every third cycle -> wr_cnt advances only on handshakes, and the contents are correct.
- start pulses during LOAD and READ -> ignored. num_passes=0 -> behaves as a single pass.
- rst asserted at load word 100, then a new start with a full codeword -> no stale done. The second readback matches the second data set, and busy and out_valid are 0 on the cycle after reset.
